// File: rtl/skid_buffer.sv
// Two-entry valid/ready stage: registered main word plus skid word.
// Ready, valid and data all leave from flops.
module skid_buffer #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // The encoding doubles as the occupancy count.
  assign count_o     = state_q;
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != FULL);
  assign out_data_o  = main_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Data words are left stale; only occupancy clears.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer (Width=4): directed
// scenarios plus random traffic against a queue model.
module tb_skid_buffer;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic [W-1:0] in_data_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [1:0]   count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];

  skid_buffer #(.Width(W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock: drive at negedge, update the FIFO model at the
  // posedge, return 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d,
                     input logic r, input logic f);
    int  sz;
    bit  in_x;
    bit  out_x;
    @(negedge clk_i);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk_i);
    sz    = q.size();
    in_x  = v && (sz < 2);
    out_x = r && (sz > 0);
    if (f) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    q.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b exp=0", out_valid_o);
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=1", in_ready_o);
    end
    n_cmp++;
    if (count_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d exp=0", count_o);
    end
    n_cmp++;
    if (out_data_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data got=%0d exp=0", out_data_o);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[4] = '{4'd5, 4'd7, 4'd9, 4'd2};
    for (int i = 0; i < 4; i++) begin
      cyc(1, vals[i], 1, 0);
      n_cmp++;
      if (out_valid_o !== 1'b1 || out_data_o !== vals[i]) begin
        n_fail++;
        $display("FAIL stream_data[%0d] got=%b/%0d exp=1/%0d",
                 i, out_valid_o, out_data_o, vals[i]);
      end
      n_cmp++;
      if (count_o !== 2'd1 || in_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_occ[%0d] got=%0d/%b exp=1/1",
                 i, count_o, in_ready_o);
      end
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain got=%0d/%b exp=0/0",
               count_o, out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    cyc(1, 3, 0, 0);
    cyc(1, 4, 0, 0);
    n_cmp++;
    if (count_o !== 2'd2 || in_ready_o !== 1'b0 ||
        out_data_o !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_full got=%0d/%b/%0d exp=2/0/3",
               count_o, in_ready_o, out_data_o);
    end
    cyc(1, 6, 0, 0);
    n_cmp++;
    if (count_o !== 2'd2 || out_data_o !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_ignore got=%0d/%0d exp=2/3",
               count_o, out_data_o);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (out_data_o !== 4'd4 || count_o !== 2'd1 ||
        in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second got=%0d/%0d/%b exp=4/1/1",
               out_data_o, count_o, in_ready_o);
    end
    cyc(1, 6, 1, 0);
    n_cmp++;
    if (out_data_o !== 4'd6 || count_o !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_third got=%0d/%0d exp=6/1",
               out_data_o, count_o);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (count_o !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain got=%0d exp=0", count_o);
    end
  endtask

  task automatic test_stall_hold();
    cyc(1, 8, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      n_cmp++;
      if (out_valid_o !== 1'b1 || out_data_o !== 4'd8) begin
        n_fail++;
        $display("FAIL stall[%0d] got=%b/%0d exp=1/8",
                 i, out_valid_o, out_data_o);
      end
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_flush();
    cyc(1, 10, 0, 0);
    cyc(1, 11, 0, 0);
    cyc(1, 12, 0, 1);
    n_cmp++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0 ||
        in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full got=%0d/%b/%b exp=0/0/1",
               count_o, out_valid_o, in_ready_o);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_nodeliver got=%b exp=0", out_valid_o);
    end
    // Input offered while ready: flush must still win.
    cyc(1, 13, 0, 0);
    cyc(1, 14, 0, 1);
    n_cmp++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy got=%0d/%b exp=0/0",
               count_o, out_valid_o);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 5, 0, 0);
    cyc(1, 6, 0, 0);
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    q.delete();
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        count_o !== 2'd0 || out_data_o !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst got=%b/%b/%0d/%0d exp=0/1/0/0",
               out_valid_o, in_ready_o, count_o, out_data_o);
    end
    #1 rst_ni = 1'b1;
    cyc(1, 1, 1, 0);
    n_cmp++;
    if (out_data_o !== 4'd1 || count_o !== 2'd1) begin
      n_fail++;
      $display("FAIL async_push got=%0d/%0d exp=1/1",
               out_data_o, count_o);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_alone got=%0d/%b exp=0/0",
               count_o, out_valid_o);
    end
  endtask

  task automatic test_random();
    logic v;
    logic r;
    logic f;
    logic [W-1:0] d;
    int sz;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      f = 1'($urandom_range(0, 19) == 0);
      d = W'($urandom);
      cyc(v, d, r, f);
      sz = q.size();
      n_cmp++;
      if (count_o !== 2'(sz) ||
          out_valid_o !== (sz > 0) ||
          in_ready_o !== (sz < 2)) begin
        n_fail++;
        $display("FAIL rand_occ[%0d] got=%0d/%b/%b exp=%0d",
                 i, count_o, out_valid_o, in_ready_o, sz);
      end
      if (sz > 0) begin
        n_cmp++;
        if (out_data_o !== q[0]) begin
          n_fail++;
          $display("FAIL rand_data[%0d] got=%0d exp=%0d",
                   i, out_data_o, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
